// File: rtl/tx_dqpsk_modulator.sv
// ---------------------------------------------------------------------------
// tx_dqpsk_modulator
//   Turns a byte stream into 24-bit complex baseband samples {I[11:0], Q[11:0]}.
//   Each frame starts with a run of preamble symbols (dibit 2'b11). The payload
//   dibits follow, MSB dibit first. Symbols are differentially encoded as
//   Gray-coded phase increments, so a receiver can ignore any 90-degree carrier
//   rotation. Every symbol is held for SPS output samples.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   in_valid   payload byte valid
//   in_data    payload byte
//   in_last    final byte of the frame
//   in_ready   byte accepted when in_valid && in_ready
//   out_valid  sample valid
//   out_data   {I, Q} sample, I in [23:12]
//   out_ready  sample taken when out_valid && out_ready
//   underrun   1-cycle pulse: a byte was needed mid-frame and none was offered
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no frame; waiting for the first byte
// S_PREAMBLE| emitting PREAMBLE_SYMS symbols of dibit 2'b11
// S_DATA    | emitting the 4 dibits of the latched byte
// S_WAIT    | underrun mid-frame; phase held until the next byte arrives
// ---------------------------------------------------------------------------
module tx_dqpsk_modulator #(
  parameter int SPS           = 4,
  parameter int PREAMBLE_SYMS = 16,
  parameter int AMP           = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [23:0] out_data,
  input  logic        out_ready,
  output logic        underrun
);

  localparam int SW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int PW = (PREAMBLE_SYMS > 1) ? $clog2(PREAMBLE_SYMS) : 1;
  // sym_cnt is shared by the preamble and the data phase, so it must hold 0..3 too.
  localparam int CW = (PW > 2) ? PW : 2;

  localparam logic [SW-1:0] SAMP_LAST = SW'(SPS - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_SYMS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(3);
  localparam logic [11:0]   POS_AMP   = 12'(AMP);
  localparam logic [11:0]   NEG_AMP   = 12'(-AMP);
  localparam logic [1:0]    PRE_DIBIT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [1:0]      phase, phase_nxt;
  logic [SW-1:0]   samp_cnt, samp_nxt;
  logic [CW-1:0]   sym_cnt, sym_nxt;
  logic [7:0]      byte_q, byte_nxt;
  logic            last_q, last_nxt;
  logic            underrun_q, underrun_nxt;
  logic            in_ready_c;
  logic            out_hs;
  logic            samp_last;
  logic [11:0]     i_val, q_val;

  // Gray map: adjacent dibits differ by one bit and by one quarter turn.
  function automatic logic [1:0] gray_inc(input logic [1:0] dibit);
    logic [1:0] inc;
    case (dibit)
      2'b00:   inc = 2'd0;
      2'b01:   inc = 2'd1;
      2'b11:   inc = 2'd2;
      default: inc = 2'd3;
    endcase
    return inc;
  endfunction

  function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] idx);
    logic [1:0] d;
    case (idx)
      2'd0:    d = b[7:6];
      2'd1:    d = b[5:4];
      2'd2:    d = b[3:2];
      default: d = b[1:0];
    endcase
    return d;
  endfunction

  assign out_valid = (state == S_PREAMBLE) || (state == S_DATA);
  assign out_hs    = out_valid && out_ready;
  assign samp_last = (samp_cnt == SAMP_LAST);
  assign in_ready  = in_ready_c && !rst;
  assign underrun  = underrun_q;

  // I is negative for phases 1 and 2, Q for phases 2 and 3.
  assign i_val    = (phase[1] ^ phase[0]) ? NEG_AMP : POS_AMP;
  assign q_val    = phase[1] ? NEG_AMP : POS_AMP;
  assign out_data = out_valid ? {i_val, q_val} : 24'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      phase      <= 2'd0;
      samp_cnt   <= '0;
      sym_cnt    <= '0;
      byte_q     <= 8'd0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      samp_cnt   <= samp_nxt;
      sym_cnt    <= sym_nxt;
      byte_q     <= byte_nxt;
      last_q     <= last_nxt;
      underrun_q <= underrun_nxt;
    end
  end

  // phase always holds the phase of the symbol currently on out_data, so the
  // increment for a new symbol is applied as that symbol is entered.
  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    samp_nxt     = samp_cnt;
    sym_nxt      = sym_cnt;
    byte_nxt     = byte_q;
    last_nxt     = last_q;
    underrun_nxt = 1'b0;
    in_ready_c   = 1'b0;

    case (state)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          byte_nxt  = in_data;
          last_nxt  = in_last;
          phase_nxt = gray_inc(PRE_DIBIT);
          samp_nxt  = '0;
          sym_nxt   = '0;
          state_nxt = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        if (out_hs) begin
          if (!samp_last) begin
            samp_nxt = samp_cnt + SW'(1);
          end else begin
            samp_nxt = '0;
            if (sym_cnt == PRE_LAST) begin
              sym_nxt   = '0;
              phase_nxt = phase + gray_inc(dibit_of(byte_q, 2'd0));
              state_nxt = S_DATA;
            end else begin
              sym_nxt   = sym_cnt + CW'(1);
              phase_nxt = phase + gray_inc(PRE_DIBIT);
            end
          end
        end
      end

      S_DATA: begin
        if (out_hs) begin
          if (!samp_last) begin
            samp_nxt = samp_cnt + SW'(1);
          end else begin
            samp_nxt = '0;
            if (sym_cnt != DATA_LAST) begin
              sym_nxt   = sym_cnt + CW'(1);
              phase_nxt = phase + gray_inc(dibit_of(byte_q, sym_cnt[1:0] + 2'd1));
            end else begin
              sym_nxt = '0;
              if (last_q) begin
                state_nxt = S_IDLE;
              end else begin
                // Only here does in_ready depend on out_ready: the next byte is
                // taken in the same cycle as the final sample, leaving no gap.
                in_ready_c = 1'b1;
                if (in_valid) begin
                  byte_nxt  = in_data;
                  last_nxt  = in_last;
                  phase_nxt = phase + gray_inc(in_data[7:6]);
                end else begin
                  underrun_nxt = 1'b1;
                  state_nxt    = S_WAIT;
                end
              end
            end
          end
        end
      end

      S_WAIT: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          byte_nxt  = in_data;
          last_nxt  = in_last;
          phase_nxt = phase + gray_inc(in_data[7:6]);
          samp_nxt  = '0;
          sym_nxt   = '0;
          state_nxt = S_DATA;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_dqpsk_modulator.sv
module tb_tx_dqpsk_modulator;

  localparam int SPS = 4;
  localparam int PRE = 8;

  localparam logic [23:0] PP = 24'h400400;
  localparam logic [23:0] MP = 24'hC00400;
  localparam logic [23:0] MM = 24'hC00C00;
  localparam logic [23:0] PM = 24'h400C00;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_ready;
  logic        underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt = 0;
  int valid_cycles = 0;
  int valid_falls = 0;
  int underrun_cnt = 0;
  int rdy_mode = 0;
  int m_phase = 0;
  bit prev_valid = 1'b0;

  logic [23:0] exp_q[$];
  logic [23:0] iq_tbl [4] = '{24'h400400, 24'hC00400, 24'hC00C00, 24'h400C00};

  tx_dqpsk_modulator #(.SPS(SPS), .PREAMBLE_SYMS(PRE), .AMP(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (out_valid) valid_cycles++;
    if (prev_valid && !out_valid) valid_falls++;
    prev_valid = out_valid;
    if (underrun) underrun_cnt++;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_sample", {31'd0, out_valid}, 32'd0);
      end else if (out_ready) begin
        chk("sample", {8'd0, out_data}, {8'd0, exp_q.pop_front()});
        hs_cnt++;
      end else begin
        chk("stall_hold", {8'd0, out_data}, {8'd0, exp_q[0]});
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic push_n(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic push_preamble_lit();
    for (int i = 0; i < PRE / 2; i++) begin
      push_n(MM, 4);
      push_n(PP, 4);
    end
  endtask

  task automatic push_test1();
    push_preamble_lit();
    push_n(PP, 4); push_n(MP, 4); push_n(PP, 4); push_n(MM, 4);
  endtask

  task automatic model_sym(input logic [1:0] d);
    int inc;
    case (d)
      2'b00:   inc = 0;
      2'b01:   inc = 1;
      2'b11:   inc = 2;
      default: inc = 3;
    endcase
    m_phase = (m_phase + inc) % 4;
    push_n(iq_tbl[m_phase], SPS);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit first);
    if (first) begin
      m_phase = 0;
      for (int s = 0; s < PRE; s++) model_sym(2'b11);
    end
    for (int k = 0; k < 4; k++) model_sym(b[7-2*k -: 2]);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    bit got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!got && n < 2000) begin
      @(negedge clk);
      got = in_ready;
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) chk("in_accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic clear_stats();
    valid_cycles = 0;
    valid_falls  = 0;
    underrun_cnt = 0;
    hs_cnt       = 0;
  endtask

  initial begin
    int n;
    int vc;
    int nb;
    int gap;
    logic [7:0] b;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    in_last = 1'b0;
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {8'd0, out_data}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-byte frame, out_ready held high.
    rdy_mode = 0;
    push_test1();
    send_byte(8'h1B, 1'b1);
    wait_drain("t1");
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);

    // Same frame with out_ready toggling.
    rdy_mode = 1;
    push_test1();
    send_byte(8'h1B, 1'b1);
    wait_drain("t2");
    rdy_mode = 0;

    // Back-to-back bytes, no gap in out_valid.
    repeat (3) @(posedge clk);
    clear_stats();
    push_preamble_lit();
    push_n(PP, 16);
    push_n(MM, 4); push_n(PP, 4); push_n(MM, 4); push_n(PP, 4);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b1);
    wait_drain("t3");
    chk("t3_valid_cycles", valid_cycles, 64);
    chk("t3_valid_falls", valid_falls, 1);

    // Underrun mid-frame, resume without preamble.
    clear_stats();
    push_preamble_lit();
    push_n(PP, 16);
    send_byte(8'h00, 1'b0);
    wait_drain("t4a");
    chk("t4_underrun_cnt", underrun_cnt, 1);
    chk("t4_wait_in_ready", {31'd0, in_ready}, 32'd1);
    vc = valid_cycles;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_gap_valid", valid_cycles, vc);
    push_n(MP, 4); push_n(MM, 4); push_n(PM, 4); push_n(PP, 4);
    send_byte(8'h55, 1'b1);
    wait_drain("t4b");
    chk("t4_underrun_once", underrun_cnt, 1);

    // Reset during data sample 5.
    clear_stats();
    push_test1();
    send_byte(8'h1B, 1'b1);
    n = 0;
    while (hs_cnt < PRE * SPS + 5 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t5_reach", hs_cnt, PRE * SPS + 5);
    @(posedge clk);
    #3;
    chk("t5_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_data", {8'd0, out_data}, 32'd0);
    chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_post_valid", {31'd0, out_valid}, 32'd0);
    push_test1();
    send_byte(8'h1B, 1'b1);
    wait_drain("t5");

    // Random frames with random back-pressure and occasional underruns.
    rdy_mode = 2;
    for (int f = 0; f < 12; f++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        gap = ($urandom_range(0, 5) == 0) ? 40 : $urandom_range(0, 2);
        if (k > 0) repeat (gap) @(posedge clk);
        b = 8'($urandom_range(0, 255));
        model_byte(b, k == 0);
        send_byte(b, k == nb - 1);
      end
      wait_drain("rnd");
    end
    rdy_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
